gbc_work_ram_target: RTL and testbench

Responder (target) end of the `IRetroMemoryPort` protocol that backs the CGB work RAM. `GBCMemoryBus` drives its `SystemRAM` initiator port into this block. The block wraps a single-port synchronous block RAM with a request/acknowledge state machine and a power-on / on-demand zero-fill sequencer. While it fills, `Ready` is held low, so the bus stalls the CPU.

---
 rtl/gbc_work_ram_target.sv | 156 +++++++++++++++
 tb/tb_gbc_work_ram_target.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gbc_work_ram_target.sv
// gbc_work_ram_target
//   Target end of the retro memory port backing the CGB work RAM. Wraps a
//   single-port synchronous block RAM with a request/acknowledge FSM and a
//   zero-fill sequencer that runs after reset and on ClearReq. Ready stays low
//   while a fill is running, which stalls the initiator.
//
// Ports
//   Clk                    system clock
//   nReset                 asynchronous active-low reset
//   ClkEn                  clock enable; nothing advances while low
//   ClearReq               request a full re-fill with InitValue
//   MemoryPortAccess       request valid
//   MemoryPortWrite        1 = write, 0 = read (qualified by Access)
//   MemoryPortAddress      byte address
//   MemoryPortDToTarget    write data
//   MemoryPortDToInitiator read data, registered, holds until the next read
//   MemoryPortReady        a request is accepted this cycle when Access=1
//   MemoryPortDataReady    one-cycle completion pulse
//   Busy                   fill in progress
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | writing InitValue to every address, requests ignored
// IDLE  | accepting requests (unless a clear is pending)
// READ  | RAM read in flight, data latched on the next enabled edge
module gbc_work_ram_target #(
    parameter              DeviceType = "Xilinx",
    parameter int          AddrBits   = 15,
    parameter logic [7:0]  InitValue  = 8'h00
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                ClkEn,
    input  logic                ClearReq,
    input  logic                MemoryPortAccess,
    input  logic                MemoryPortWrite,
    input  logic [AddrBits-1:0] MemoryPortAddress,
    input  logic [7:0]          MemoryPortDToTarget,
    output logic [7:0]          MemoryPortDToInitiator,
    output logic                MemoryPortReady,
    output logic                MemoryPortDataReady,
    output logic                Busy
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        READ
    } StateT;

    localparam int                Depth    = 2 ** AddrBits;
    localparam logic [AddrBits-1:0] LastAddr = '1;

    StateT               state;
    logic [AddrBits-1:0] clearCnt;
    logic                clearPending;

    logic                accept;
    logic                ramWe;
    logic [AddrBits-1:0] ramAddr;
    logic [7:0]          ramWData;
    logic [7:0]          ramQ;

    // Ready is only ever high in IDLE, so it alone qualifies an access.
    assign accept   = MemoryPortAccess & MemoryPortReady;
    assign ramWe    = (state == CLEAR) | (accept & MemoryPortWrite);
    assign ramAddr  = (state == CLEAR) ? clearCnt : MemoryPortAddress;
    assign ramWData = (state == CLEAR) ? InitValue : MemoryPortDToTarget;
    assign Busy     = (state == CLEAR);

    // Read-first single-port RAM; contents are not reset.
    generate
        if (DeviceType == "Xilinx") begin : gXilinxRam
            (* ram_style = "block" *) logic [7:0] mem [Depth];
            always_ff @(posedge Clk) begin
                if (ClkEn) begin
                    if (ramWe) begin
                        mem[ramAddr] <= ramWData;
                    end
                    ramQ <= mem[ramAddr];
                end
            end
        end else begin : gGenericRam
            (* ramstyle = "no_rw_check" *) logic [7:0] mem [Depth];
            always_ff @(posedge Clk) begin
                if (ClkEn) begin
                    if (ramWe) begin
                        mem[ramAddr] <= ramWData;
                    end
                    ramQ <= mem[ramAddr];
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state                  <= CLEAR;
            clearCnt               <= '0;
            clearPending           <= 1'b0;
            MemoryPortReady        <= 1'b0;
            MemoryPortDataReady    <= 1'b0;
            MemoryPortDToInitiator <= 8'h00;
        end else if (ClkEn) begin
            MemoryPortDataReady <= 1'b0;
            case (state)
                CLEAR: begin
                    // ClearReq is deliberately not sampled here: a fill in
                    // progress is never restarted.
                    if (clearCnt == LastAddr) begin
                        clearCnt        <= '0;
                        state           <= IDLE;
                        MemoryPortReady <= 1'b1;
                    end else begin
                        clearCnt <= clearCnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (clearPending) begin
                        clearPending    <= 1'b0;
                        state           <= CLEAR;
                        MemoryPortReady <= 1'b0;
                    end else begin
                        if (ClearReq) begin
                            clearPending <= 1'b1;
                        end
                        MemoryPortReady <= ~ClearReq;
                        if (accept) begin
                            if (MemoryPortWrite) begin
                                MemoryPortDataReady <= 1'b1;
                            end else begin
                                state           <= READ;
                                MemoryPortReady <= 1'b0;
                            end
                        end
                    end
                end
                READ: begin
                    MemoryPortDToInitiator <= ramQ;
                    MemoryPortDataReady    <= 1'b1;
                    state                  <= IDLE;
                    if (ClearReq) begin
                        clearPending <= 1'b1;
                    end
                    MemoryPortReady <= ~(clearPending | ClearReq);
                end
                default: begin
                    state           <= CLEAR;
                    clearCnt        <= '0;
                    MemoryPortReady <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gbc_work_ram_target.sv
// Directed bench for gbc_work_ram_target: fill timing, write/read timing,
// streaming, clock-enable stalls, clear-during-read and reset aborts.
module tb_gbc_work_ram_target;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        ClkEn;
    logic        ClearReq;
    logic        Access;
    logic        Write;
    logic [14:0] Address;
    logic [7:0]  DToTarget;
    logic [7:0]  DToInitiator;
    logic        Ready;
    logic        DataReady;
    logic        Busy;

    int vectors     = 0;
    int miscompares = 0;
    int cnt;

    gbc_work_ram_target dut (
        .Clk                    (Clk),
        .nReset                 (nReset),
        .ClkEn                  (ClkEn),
        .ClearReq               (ClearReq),
        .MemoryPortAccess       (Access),
        .MemoryPortWrite        (Write),
        .MemoryPortAddress      (Address),
        .MemoryPortDToTarget    (DToTarget),
        .MemoryPortDToInitiator (DToInitiator),
        .MemoryPortReady        (Ready),
        .MemoryPortDataReady    (DataReady),
        .Busy                   (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Counts cycles with Ready=0, starting with the current one.
    task automatic fillWait(input int bound, input int pokeAt, output int n);
        n = 0;
        while (!Ready && n < bound) begin
            n++;
            if (n == pokeAt) ClearReq = 1'b1;
            tick();
            ClearReq = 1'b0;
        end
    endtask

    task automatic doWrite(input logic [14:0] a, input logic [7:0] d);
        checkVal("wr_ready_pre", 16'(Ready), 16'd1);
        Access = 1'b1; Write = 1'b1; Address = a; DToTarget = d;
        tick();
        Access = 1'b0; Write = 1'b0;
        checkVal("wr_dataready", 16'(DataReady), 16'd1);
        checkVal("wr_ready", 16'(Ready), 16'd1);
        tick();
        checkVal("wr_dataready_end", 16'(DataReady), 16'd0);
    endtask

    task automatic doRead(input string tag, input logic [14:0] a, input logic [7:0] e);
        Access = 1'b1; Write = 1'b0; Address = a;
        tick();
        Access = 1'b0;
        checkVal({tag, "_ready_n1"}, 16'(Ready), 16'd0);
        checkVal({tag, "_dr_n1"}, 16'(DataReady), 16'd0);
        tick();
        checkVal({tag, "_dr_n2"}, 16'(DataReady), 16'd1);
        checkVal({tag, "_data"}, 16'(DToInitiator), 16'(e));
        checkVal({tag, "_ready_n2"}, 16'(Ready), 16'd1);
    endtask

    initial begin
        nReset = 1'b0; ClkEn = 1'b1; ClearReq = 1'b0;
        Access = 1'b0; Write = 1'b0; Address = '0; DToTarget = '0;
        #2;
        checkVal("rst_ready", 16'(Ready), 16'd0);
        checkVal("rst_dataready", 16'(DataReady), 16'd0);
        checkVal("rst_dout", 16'(DToInitiator), 16'h00);
        checkVal("rst_busy", 16'(Busy), 16'd1);
        tick();
        nReset = 1'b1;

        // Reset mid-fill at fill cycle 1000, then a full fill.
        repeat (1000) tick();
        checkVal("fill_mid_ready", 16'(Ready), 16'd0);
        checkVal("fill_mid_busy", 16'(Busy), 16'd1);
        nReset = 1'b0;
        #1;
        checkVal("midfill_rst_ready", 16'(Ready), 16'd0);
        checkVal("midfill_rst_busy", 16'(Busy), 16'd1);
        checkVal("midfill_rst_dr", 16'(DataReady), 16'd0);
        tick();
        nReset = 1'b1;
        fillWait(33000, 0, cnt);
        checkVal("fill_cycles", 16'(cnt), 16'(32768));
        checkVal("fill_done_busy", 16'(Busy), 16'd0);
        checkVal("fill_done_ready", 16'(Ready), 16'd1);

        doRead("rd0000", 15'h0000, 8'h00);
        doRead("rd4abc", 15'h4ABC, 8'h00);
        doRead("rd7fff", 15'h7FFF, 8'h00);

        // Write then read.
        doWrite(15'h1234, 8'hA5);
        doRead("rd1234", 15'h1234, 8'hA5);

        // Streaming writes, one per cycle, then back-to-back reads.
        Access = 1'b1; Write = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Address = 15'(16 + i); DToTarget = 8'(16 + i);
            tick();
            checkVal("stream_wr_dr", 16'(DataReady), 16'd1);
            checkVal("stream_wr_ready", 16'(Ready), 16'd1);
        end
        Access = 1'b0; Write = 1'b0;
        tick();
        checkVal("stream_wr_dr_end", 16'(DataReady), 16'd0);
        for (int i = 0; i < 16; i++) begin
            doRead("stream_rd", 15'(16 + i), 8'(16 + i));
        end

        // Clock enable toggling during a read of 0x15.
        Access = 1'b1; Write = 1'b0; Address = 15'h0015;
        tick();
        Access = 1'b0; ClkEn = 1'b0;
        checkVal("ce_ready_n1", 16'(Ready), 16'd0);
        tick();
        checkVal("ce_hold_ready", 16'(Ready), 16'd0);
        checkVal("ce_hold_dr", 16'(DataReady), 16'd0);
        checkVal("ce_hold_dout", 16'(DToInitiator), 16'h1F);
        ClkEn = 1'b1;
        tick();
        checkVal("ce_dr", 16'(DataReady), 16'd1);
        checkVal("ce_dout", 16'(DToInitiator), 16'h15);
        ClkEn = 1'b0;
        tick();
        checkVal("ce_dr_hold", 16'(DataReady), 16'd1);
        checkVal("ce_dout_hold", 16'(DToInitiator), 16'h15);
        ClkEn = 1'b1;
        tick();
        checkVal("ce_dr_end", 16'(DataReady), 16'd0);
        checkVal("ce_dout_end", 16'(DToInitiator), 16'h15);

        // Clear requested in the cycle a read is accepted; a second ClearReq
        // during the fill must not restart it.
        doWrite(15'h0100, 8'h3C);
        Access = 1'b1; Write = 1'b0; Address = 15'h0100; ClearReq = 1'b1;
        tick();
        Access = 1'b0; ClearReq = 1'b0;
        checkVal("clr_rd_ready_n1", 16'(Ready), 16'd0);
        tick();
        checkVal("clr_rd_dr", 16'(DataReady), 16'd1);
        checkVal("clr_rd_data", 16'(DToInitiator), 16'h3C);
        checkVal("clr_rd_ready_n2", 16'(Ready), 16'd0);
        tick();
        checkVal("clr_busy", 16'(Busy), 16'd1);
        fillWait(33000, 500, cnt);
        checkVal("clr_fill_cycles", 16'(cnt), 16'(32768));
        doRead("clr_reread", 15'h0100, 8'h00);
        checkVal("clr_no_refill", 16'(Busy), 16'd0);

        // Reset in the middle of a read aborts it.
        doWrite(15'h0200, 8'h5A);
        doRead("rd0200", 15'h0200, 8'h5A);
        Access = 1'b1; Write = 1'b0; Address = 15'h0200;
        tick();
        Access = 1'b0;
        nReset = 1'b0;
        #1;
        checkVal("midrd_rst_ready", 16'(Ready), 16'd0);
        checkVal("midrd_rst_dr", 16'(DataReady), 16'd0);
        checkVal("midrd_rst_dout", 16'(DToInitiator), 16'h00);
        checkVal("midrd_rst_busy", 16'(Busy), 16'd1);
        tick();
        nReset = 1'b1;
        repeat (2000) tick();
        checkVal("midrd_refill_ready", 16'(Ready), 16'd0);
        checkVal("midrd_refill_busy", 16'(Busy), 16'd1);
        checkVal("midrd_refill_dr", 16'(DataReady), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
